// File: rtl/tx_block_ap_regs.sv
// rtl/tx_block_ap_regs.sv - AXI4-Lite slave with four 32-bit control registers for the TX_Block_AP datapath
module tx_block_ap_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    output logic [3:0]                      reg_wr_stb_o
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int NB = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic              aw_have_q, w_have_q;
    logic [AW-1:0]     awaddr_q;
    logic [DW-1:0]     wdata_q;
    logic [NB-1:0]     wstrb_q;
    logic [DW-1:0]     regs_q [4];
    logic [1:0]        bresp_q, rresp_q;
    logic [DW-1:0]     rdata_q;
    logic              aw_hs, w_hs, ar_hs;
    logic              aw_oor, ar_oor;
    logic [3:0]        stb;
    logic              unused_ok;

    assign S_AXI_AWREADY = !ARESET && (w_state_q == W_COLLECT) && !aw_have_q;
    assign S_AXI_WREADY  = !ARESET && (w_state_q == W_COLLECT) && !w_have_q;
    assign S_AXI_ARREADY = !ARESET && (r_state_q == R_IDLE);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign reg0_o       = regs_q[0];
    assign reg1_o       = regs_q[1];
    assign reg2_o       = regs_q[2];
    assign reg3_o       = regs_q[3];
    assign reg_wr_stb_o = stb;

    // Any address bit above the 16-byte window makes the access out of range.
    generate
        if (AW > 4) begin : g_oor
            assign aw_oor = |awaddr_q[AW-1:4];
            assign ar_oor = |S_AXI_ARADDR[AW-1:4];
        end else begin : g_no_oor
            assign aw_oor = 1'b0;
            assign ar_oor = 1'b0;
        end
    endgenerate

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        stb       = 4'b0000;
        case (w_state_q)
            W_COLLECT: begin
                if ((aw_have_q || aw_hs) && (w_have_q || w_hs))
                    w_state_d = W_COMMIT;
            end
            W_COMMIT: begin
                w_state_d = W_RESP;
                if (!aw_oor)
                    stb[awaddr_q[3:2]] = 1'b1;
            end
            W_RESP: begin
                if (S_AXI_BREADY)
                    w_state_d = W_COLLECT;
            end
            default: w_state_d = W_COLLECT;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_COLLECT;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            for (int k = 0; k < 4; k++)
                regs_q[k] <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                awaddr_q  <= S_AXI_AWADDR;
                aw_have_q <= 1'b1;
            end
            if (w_hs) begin
                wdata_q  <= S_AXI_WDATA;
                wstrb_q  <= S_AXI_WSTRB;
                w_have_q <= 1'b1;
            end
            if (w_state_q == W_COMMIT) begin
                aw_have_q <= 1'b0;
                w_have_q  <= 1'b0;
                bresp_q   <= aw_oor ? RESP_SLVERR : RESP_OKAY;
                for (int k = 0; k < 4; k++)
                    for (int b = 0; b < NB; b++)
                        if (stb[k] && wstrb_q[b])
                            regs_q[k][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // Capture happens before any same-edge commit lands, so reads see the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                rdata_q <= ar_oor ? '0 : regs_q[S_AXI_ARADDR[3:2]];
                rresp_q <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end
endmodule

// File: tb/tb_tx_block_ap_regs.sv
// tb/tb_tx_block_ap_regs.sv - directed self-checking bench for tx_block_ap_regs
module tb_tx_block_ap_regs;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [7:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
    logic [3:0]  reg_wr_stb_o;

    int asserts  = 0;
    int failures = 0;
    int stb_cycles = 0;

    always #5 ACLK = ~ACLK;

    tx_block_ap_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
        .reg_wr_stb_o(reg_wr_stb_o)
    );

    always @(negedge ACLK)
        if (|reg_wr_stb_o) stb_cycles++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Issues AW and W together; holds BREADY low for bdelay cycles once BVALID rises.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int bdelay, output logic [1:0] resp, output logic [3:0] stb,
                             output logic bp_ok);
        bit aw_done, w_done, aw_hit, w_hit;
        int n;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        aw_done = 0; w_done = 0; n = 0; bp_ok = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hit = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hit  = S_AXI_WVALID && S_AXI_WREADY;
            step(); n++;
            if (aw_hit) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_hit)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
        end
        chk("wr_handshake_timeout", {31'd0, aw_done && w_done}, 32'd1);
        stb = reg_wr_stb_o;
        step();
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin step(); n++; end
        chk("bvalid_timeout", {31'd0, S_AXI_BVALID}, 32'd1);
        for (int i = 0; i < bdelay; i++) begin
            if (!S_AXI_BVALID || S_AXI_AWREADY || S_AXI_WREADY) bp_ok = 1'b0;
            step();
        end
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp, output logic bp_ok);
        bit hit, done;
        int n;
        logic [31:0] first;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        done = 0; n = 0; bp_ok = 1'b1;
        while (!done && n < 20) begin
            hit = S_AXI_ARREADY;
            step(); n++;
            if (hit) begin done = 1; S_AXI_ARVALID = 1'b0; end
        end
        chk("rvalid_next_cycle", {31'd0, S_AXI_RVALID}, 32'd1);
        first = S_AXI_RDATA;
        for (int i = 0; i < rdelay; i++) begin
            if (!S_AXI_RVALID || S_AXI_ARREADY || S_AXI_RDATA !== first) bp_ok = 1'b0;
            step();
        end
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [3:0]  stb;
        logic [31:0] rd;
        logic        bp;
        logic [31:0] exp_vals [4];
        bit          wready_low;
        int          base;

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        step(); step(); step();

        chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        chk("rst_wready", {31'd0, S_AXI_WREADY}, 32'd0);
        chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        chk("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        chk("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("rst_rdata", S_AXI_RDATA, 32'd0);
        chk("rst_stb", {28'd0, reg_wr_stb_o}, 32'd0);
        chk("rst_regs", reg0_o | reg1_o | reg2_o | reg3_o, 32'd0);
        ARESET = 1'b0;
        step();
        chk("post_rst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        chk("post_rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

        // Sequential writes then reads
        exp_vals = '{32'h1, 32'h2, 32'h4, 32'h8};
        base = stb_cycles;
        for (int k = 0; k < 4; k++) begin
            axi_write(8'(4*k), 32'(k+1), 4'hF, 0, resp, stb, bp);
            chk($sformatf("seq_bresp%0d", k), {30'd0, resp}, 32'd0);
            chk($sformatf("seq_stb%0d", k), {28'd0, stb}, exp_vals[k]);
        end
        chk("seq_stb_cycles", 32'(stb_cycles - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            axi_read(8'(4*k), 0, rd, resp, bp);
            chk($sformatf("seq_rdata%0d", k), rd, 32'(k+1));
            chk($sformatf("seq_rresp%0d", k), {30'd0, resp}, 32'd0);
        end

        // W ahead of AW by three cycles
        S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_WVALID = 1'b0;
        wready_low = 1;
        for (int i = 0; i < 3; i++) begin
            if (S_AXI_WREADY) wready_low = 0;
            step();
        end
        chk("wfirst_wready_low", {31'd0, wready_low}, 32'd1);
        chk("wfirst_reg2_before", reg2_o, 32'h3);
        S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        chk("wfirst_stb", {28'd0, reg_wr_stb_o}, 32'h4);
        step();
        chk("wfirst_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        chk("wfirst_reg2", reg2_o, 32'hA5A5A5A5);
        S_AXI_BREADY = 1'b1; step(); S_AXI_BREADY = 1'b0;

        // Byte strobes
        axi_write(8'h04, 32'h11223344, 4'hF, 0, resp, stb, bp);
        axi_write(8'h04, 32'hFFFFFFFF, 4'b0101, 0, resp, stb, bp);
        chk("strb_reg1", reg1_o, 32'h11FF33FF);
        axi_write(8'h04, 32'h00000000, 4'b0000, 0, resp, stb, bp);
        chk("strb0_reg1", reg1_o, 32'h11FF33FF);
        chk("strb0_stb", {28'd0, stb}, 32'h2);
        chk("strb0_bresp", {30'd0, resp}, 32'd0);

        // Backpressure on B and R
        axi_write(8'h0C, 32'h77, 4'hF, 10, resp, stb, bp);
        chk("bp_write_hold", {31'd0, bp}, 32'd1);
        chk("bp_reg3", reg3_o, 32'h77);
        axi_write(8'h0C, 32'h88, 4'hF, 0, resp, stb, bp);
        chk("bp_next_write", reg3_o, 32'h88);
        axi_read(8'h08, 10, rd, resp, bp);
        chk("bp_read_hold", {31'd0, bp}, 32'd1);
        chk("bp_read_data", rd, 32'hA5A5A5A5);
        axi_read(8'h07, 0, rd, resp, bp);
        chk("low_bits_ignored", rd, 32'h11FF33FF);

        // Out-of-range access
        base = stb_cycles;
        axi_write(8'h10, 32'hDEAD, 4'hF, 0, resp, stb, bp);
        chk("oor_bresp", {30'd0, resp}, 32'h2);
        chk("oor_stb", {28'd0, stb}, 32'd0);
        chk("oor_stb_cycles", 32'(stb_cycles - base), 32'd0);
        chk("oor_reg0", reg0_o, 32'h1);
        chk("oor_reg1", reg1_o, 32'h11FF33FF);
        chk("oor_reg2", reg2_o, 32'hA5A5A5A5);
        chk("oor_reg3", reg3_o, 32'h88);
        axi_read(8'h10, 0, rd, resp, bp);
        chk("oor_rdata", rd, 32'd0);
        chk("oor_rresp", {30'd0, resp}, 32'h2);

        // Read captured on the same edge as a commit to the same register
        axi_write(8'h00, 32'h5, 4'hF, 0, resp, stb, bp);
        S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h6; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 8'h00; S_AXI_ARVALID = 1'b1;
        chk("race_commit_stb", {28'd0, reg_wr_stb_o}, 32'h1);
        step();
        S_AXI_ARVALID = 1'b0;
        chk("race_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        chk("race_rdata_old", S_AXI_RDATA, 32'h5);
        chk("race_reg0_new", reg0_o, 32'h6);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;

        // Reset while a write response is pending
        S_AXI_AWADDR = 8'h04; S_AXI_WDATA = 32'h99; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        step();
        chk("pre_rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        ARESET = 1'b1;
        step();
        chk("mid_rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        chk("mid_rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        ARESET = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            axi_read(8'(4*k), 0, rd, resp, bp);
            chk($sformatf("rst_readback%0d", k), rd, 32'd0);
        end
        chk("rst_bvalid_after", {31'd0, S_AXI_BVALID}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
